// File: rtl/rand_stim_gen.sv
// Pseudo-random {addr, wr, en} burst generator with valid/ready backpressure.
// A Galois LFSR drives the payload; the same seed always replays the same burst.
module rand_stim_gen #(
  parameter int                ADDR_W  = 6,
  parameter int                NUM_TXN = 11,
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] TAPS    = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
  localparam int               CNT_W   = $clog2(NUM_TXN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic              seed_ld_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wr_o,
  output logic              en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  txn_cnt_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_src;
  logic [ADDR_W-1:0] addr_q, addr_d, seq_q, seq_d, seq_sel;
  logic              wr_q, wr_d, en_q, en_d, vld_q, vld_d, do_load;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d, mode_sel;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? TAPS : '0);
  endfunction

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    en_d     = en_q;
    vld_d    = vld_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    mode_d   = mode_q;
    lfsr_src = lfsr_q;
    mode_sel = mode_q;
    seq_sel  = seq_q;
    do_load  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // Seed is applied before the start load so a combined request uses it.
        if (seed_ld_i) lfsr_src = (seed_i == '0) ? SEED : seed_i;
        lfsr_d = lfsr_src;
        if (start_i) begin
          state_d  = RUN;
          mode_d   = mode_i;
          mode_sel = mode_i;
          cnt_d    = '0;
          seq_sel  = '0;
          vld_d    = 1'b1;
          do_load  = 1'b1;
        end
      end
      RUN: begin
        if (vld_q && out_ready_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (32'(cnt_q) + 32'd1 < 32'(NUM_TXN)) begin
            do_load = 1'b1;
          end else begin
            state_d = DONE;
            vld_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      lfsr_d = lfsr_next(lfsr_src);
      seq_d  = seq_sel + ADDR_W'(1);
      addr_d = (mode_sel == 2'b01) ? seq_sel : lfsr_src[ADDR_W-1:0];
      case (mode_sel)
        2'b10:   begin wr_d = 1'b1; en_d = 1'b1; end
        2'b11:   begin wr_d = 1'b0; en_d = 1'b1; end
        default: begin wr_d = lfsr_src[ADDR_W]; en_d = lfsr_src[ADDR_W+1]; end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      seq_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      en_q    <= en_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      mode_q  <= mode_d;
    end
  end

  assign out_valid_o = vld_q;
  assign addr_o      = addr_q;
  assign wr_o        = wr_q;
  assign en_o        = en_q;
  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);
  assign txn_cnt_o   = cnt_q;

endmodule

// File: tb/tb_rand_stim_gen.sv
// Bench for rand_stim_gen: randomized ready against a queue-based burst model.
module tb_rand_stim_gen;

  logic        clk = 1'b0;
  logic        rst, start, seed_ld, out_ready;
  logic [1:0]  mode;
  logic [15:0] seed;
  logic        out_valid, wr, en, busy, done;
  logic [5:0]  addr;
  logic [3:0]  txn_cnt;

  logic        start3, ready3, seed_ld3;
  logic [1:0]  mode3;
  logic [15:0] seed3;
  logic        out_valid3, wr3, en3, busy3, done3;
  logic [2:0]  addr3;
  logic [3:0]  cnt3;

  int pass_cnt = 0, total_cnt = 0;

  logic [7:0]  exp_q[$], got_q[$], ref1_q[$];
  logic [15:0] m_lfsr;
  int          cycles, unstable;

  always #5 clk = ~clk;

  rand_stim_gen dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .seed_ld_i(seed_ld),
    .seed_i(seed), .out_valid_o(out_valid), .out_ready_i(out_ready), .addr_o(addr),
    .wr_o(wr), .en_o(en), .busy_o(busy), .done_o(done), .txn_cnt_o(txn_cnt));

  rand_stim_gen #(.ADDR_W(3), .NUM_TXN(10)) dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start3), .mode_i(mode3), .seed_ld_i(seed_ld3),
    .seed_i(seed3), .out_valid_o(out_valid3), .out_ready_i(ready3), .addr_o(addr3),
    .wr_o(wr3), .en_o(en3), .busy_o(busy3), .done_o(done3), .txn_cnt_o(cnt3));

  // Reference LFSR step: shift right, xor the polynomial mask when bit 0 falls out.
  function automatic logic [15:0] step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Expected accepted payloads {addr, wr, en} for one burst from m_lfsr.
  task automatic model_burst(input logic [1:0] m, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      logic [5:0] a;
      logic       w, e;
      a = (m == 2'b01) ? 6'(i % 64) : m_lfsr[5:0];
      w = (m == 2'b10) ? 1'b1 : (m == 2'b11) ? 1'b0 : m_lfsr[6];
      e = (m[1]) ? 1'b1 : m_lfsr[7];
      exp_q.push_back({a, w, e});
      m_lfsr = step(m_lfsr);
    end
  endtask

  // Starts a burst and records accepted payloads; also counts payload changes under stall.
  task automatic collect(input logic [1:0] m, input logic sld, input logic [15:0] sv,
                         input int n, input int pct);
    logic       prev_stall;
    logic [7:0] prev_pl, cur;
    logic       rdy;
    got_q.delete();
    unstable = 0; cycles = 0; prev_stall = 1'b0; prev_pl = '0;
    start = 1'b1; mode = m; seed_ld = sld; seed = sv;
    @(posedge clk); #1;
    start = 1'b0; seed_ld = 1'b0; mode = 2'($urandom_range(3));
    while (got_q.size() < n && cycles < 1000) begin
      rdy = ($urandom_range(99) < pct);
      out_ready = rdy;
      cur = {addr, wr, en};
      if (prev_stall && cur !== prev_pl) unstable++;
      prev_stall = out_valid && !rdy;
      prev_pl = cur;
      if (out_valid && rdy) got_q.push_back(cur);
      // start and seed_ld are noise while running
      start = $urandom_range(1); seed_ld = $urandom_range(1); seed = 16'($urandom);
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0; seed_ld = 1'b0; out_ready = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; seed_ld = 0; seed = 0; mode = 0; out_ready = 0;
    start3 = 0; ready3 = 0; seed_ld3 = 0; seed3 = 0; mode3 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if ({out_valid, busy, done} !== 3'b000) $display("FAIL reset_flags got %b want 000", {out_valid, busy, done}); else pass_cnt++;
    total_cnt++; if (txn_cnt !== 4'd0) $display("FAIL reset_txn_cnt got %0d want 0", txn_cnt); else pass_cnt++;
    total_cnt++; if ({addr, wr, en} !== 8'h00) $display("FAIL reset_payload got %h want 00", {addr, wr, en}); else pass_cnt++;
    total_cnt++; if ({out_valid3, busy3, done3} !== 3'b000) $display("FAIL reset_flags3 got %b want 000", {out_valid3, busy3, done3}); else pass_cnt++;
  endtask

  task automatic test_basic();
    m_lfsr = 16'hACE1;
    model_burst(2'b00, 11);
    ref1_q = exp_q;
    collect(2'b00, 1'b0, 16'h0, 11, 100);
    total_cnt++; if (got_q.size() != 11) $display("FAIL basic_count got %0d want 11", got_q.size()); else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < 11; i++) begin
      total_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL basic_txn%0d got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (cycles != 11) $display("FAIL basic_cycles got %0d want 11", cycles); else pass_cnt++;
    total_cnt++; if ({done, busy, out_valid} !== 3'b100) $display("FAIL basic_done got %b want 100", {done, busy, out_valid}); else pass_cnt++;
    total_cnt++; if (txn_cnt !== 4'd11) $display("FAIL basic_txn_cnt got %0d want 11", txn_cnt); else pass_cnt++;
    total_cnt++; if ({addr, wr, en} !== exp_q[10]) $display("FAIL basic_hold got %h want %h", {addr, wr, en}, exp_q[10]); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    rst_pulse();
    m_lfsr = 16'hACE1;
    model_burst(2'b00, 11);
    collect(2'b00, 1'b0, 16'h0, 11, 30);
    total_cnt++; if (unstable != 0) $display("FAIL bp_stable got %0d changes want 0", unstable); else pass_cnt++;
    total_cnt++; if (got_q != ref1_q) $display("FAIL bp_sequence got %0d txns want 11 matching", got_q.size()); else pass_cnt++;
    total_cnt++; if ({done, txn_cnt} !== {1'b1, 4'd11}) $display("FAIL bp_done got %b/%0d want 1/11", done, txn_cnt); else pass_cnt++;
  endtask

  task automatic test_sweep();
    logic [4:0]  got3[$];
    logic [15:0] l;
    int          cyc;
    l = 16'hACE1; cyc = 0;
    start3 = 1'b1; mode3 = 2'b01;
    @(posedge clk); #1;
    start3 = 1'b0;
    while (got3.size() < 10 && cyc < 200) begin
      ready3 = ($urandom_range(99) < 60);
      if (out_valid3 && ready3) got3.push_back({addr3, wr3, en3});
      @(posedge clk); #1;
      cyc++;
    end
    ready3 = 1'b0;
    total_cnt++; if (got3.size() != 10) $display("FAIL sweep_count got %0d want 10", got3.size()); else pass_cnt++;
    for (int i = 0; i < got3.size(); i++) begin
      logic [4:0] e;
      e = {3'(i % 8), l[3], l[4]};
      l = step(l);
      total_cnt++; if (got3[i] !== e) $display("FAIL sweep_txn%0d got %h want %h", i, got3[i], e); else pass_cnt++;
    end
    total_cnt++; if ({done3, cnt3} !== {1'b1, 4'd10}) $display("FAIL sweep_done got %b/%0d want 1/10", done3, cnt3); else pass_cnt++;
  endtask

  task automatic test_modes();
    for (int k = 0; k < 2; k++) begin
      logic [1:0] m;
      m = k ? 2'b11 : 2'b10;
      model_burst(m, 11);
      collect(m, 1'b0, 16'h0, 11, 70);
      total_cnt++; if (got_q != exp_q) $display("FAIL mode%0d_sequence got %0d txns want 11 matching", m, got_q.size()); else pass_cnt++;
      for (int i = 0; i < got_q.size(); i++) begin
        total_cnt++; if (got_q[i][1:0] !== {~m[0], 1'b1}) $display("FAIL mode%0d_wren%0d got %b want %b", m, i, got_q[i][1:0], {~m[0], 1'b1}); else pass_cnt++;
      end
    end
  endtask

  task automatic test_seed();
    seed_ld = 1'b1; seed = 16'h0000;
    @(posedge clk); #1;
    seed_ld = 1'b0;
    collect(2'b00, 1'b0, 16'h0, 11, 100);
    total_cnt++; if (got_q != ref1_q) $display("FAIL seed_zero got %0d txns want reset-seed sequence", got_q.size()); else pass_cnt++;
    m_lfsr = 16'h1234;
    model_burst(2'b00, 11);
    collect(2'b00, 1'b1, 16'h1234, 11, 100);
    total_cnt++; if (got_q.size() == 0 || got_q[0][7:2] !== 6'h34) $display("FAIL seed_first_addr got %h want 34", got_q.size() ? got_q[0][7:2] : 6'h3f); else pass_cnt++;
    total_cnt++; if (got_q != exp_q) $display("FAIL seed_1234_sequence got %0d txns want 11 matching", got_q.size()); else pass_cnt++;
  endtask

  task automatic test_abort();
    rst_pulse();
    collect(2'b00, 1'b0, 16'h0, 5, 100);
    total_cnt++; if (got_q.size() != 5 || got_q[4] !== ref1_q[4]) $display("FAIL abort_prefix got %0d txns want 5 matching", got_q.size()); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if ({out_valid, busy, addr, txn_cnt} !== 12'h0) $display("FAIL abort_state got %b want all zero", {out_valid, busy, addr, txn_cnt}); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    collect(2'b00, 1'b0, 16'h0, 11, 100);
    total_cnt++; if (got_q != ref1_q) $display("FAIL abort_replay got %0d txns want reset-seed sequence", got_q.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_basic();
    test_backpressure();
    test_modes();
    test_seed();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
